// File: rtl/clock_timer_pkg.sv
// Shared definitions for the clock timer: register map, time-of-day field
// limits and the bit layout of the packed TIME word. The HEX display stage
// imports the same package so both sides agree on field widths and ranges.
package clock_timer_pkg;

    // Register word addresses
    localparam int unsigned REG_TIME     = 0;
    localparam int unsigned REG_CTRL     = 1;
    localparam int unsigned REG_STATUS   = 2;
    localparam int unsigned REG_PRESCALE = 3;

    // Field limits (inclusive maxima)
    localparam logic [4:0] HOUR_MAX = 5'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] SEC_MAX  = 6'd59;

    // Bit offsets of each field inside the 32-bit TIME word
    localparam int unsigned SEC_LSB  = 0;
    localparam int unsigned MIN_LSB  = 8;
    localparam int unsigned HOUR_LSB = 16;

    // Time of day as three binary fields
    typedef struct packed {
        logic [4:0] hours;
        logic [5:0] minutes;
        logic [5:0] seconds;
    } tod_t;

    localparam tod_t TOD_ZERO = '{hours: 5'd0, minutes: 6'd0, seconds: 6'd0};

    // Pack a time of day into the TIME register layout, padding bits zero
    function automatic logic [31:0] pack_time(input tod_t t);
        logic [31:0] word;
        word = 32'h0000_0000;
        word[HOUR_LSB +: 5] = t.hours;
        word[MIN_LSB  +: 6] = t.minutes;
        word[SEC_LSB  +: 6] = t.seconds;
        return word;
    endfunction

    // True when every field lies inside its legal range
    function automatic logic tod_valid(input tod_t t);
        return (t.hours <= HOUR_MAX) && (t.minutes <= MIN_MAX) && (t.seconds <= SEC_MAX);
    endfunction

endpackage

// File: rtl/clock_timer_tick_gen.sv
// Prescaler for the clock timer: divides clk down to one tick per second.
// The count is exposed so software can observe the sub-second phase.
module tick_gen #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned CNT_W       = $clog2(CLK_FREQ_HZ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync_clear,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_FREQ_HZ - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_r;

    // Prescaler count: clear wins over counting, holds while disabled
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= CNT_ZERO;
        end else if (sync_clear) begin
            count_r <= CNT_ZERO;
        end else if (enable) begin
            if (count_r == CNT_LAST) begin
                count_r <= CNT_ZERO;
            end else begin
                count_r <= count_r + CNT_ONE;
            end
        end
    end

    // Tick marks the final phase of each second while running
    assign tick  = enable && (count_r == CNT_LAST);
    assign count = count_r;

endmodule

// File: rtl/clock_timer.sv
// Time-of-day clock with an Avalon-MM register interface. A prescaler
// produces one tick per second; the top cascades seconds/minutes/hours,
// flags each midnight rollover and serves TIME/CTRL/STATUS/PRESCALE.
module clock_timer
    import clock_timer_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [DATA_WIDTH-1:0] avs_writedata,
    output logic [DATA_WIDTH-1:0] avs_readdata,
    output logic                  avs_waitrequest,
    output logic [4:0]            hours,
    output logic [5:0]            minutes,
    output logic [5:0]            seconds,
    output logic                  sec_tick
);

    localparam int unsigned CNT_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;

    localparam logic [ADDR_WIDTH-1:0] A_TIME     = ADDR_WIDTH'(REG_TIME);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL     = ADDR_WIDTH'(REG_CTRL);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS   = ADDR_WIDTH'(REG_STATUS);
    localparam logic [ADDR_WIDTH-1:0] A_PRESCALE = ADDR_WIDTH'(REG_PRESCALE);

    tod_t             time_r;
    logic             run_r;
    logic             midnight_r;
    logic             sec_tick_r;
    logic [DATA_WIDTH-1:0] readdata_r;

    logic [31:0]      wd32_s;
    tod_t             wr_tod_s;
    logic             load_time_s;
    logic             ctrl_wr_s;
    logic             clear_s;
    logic             status_w1c_s;
    logic             sync_clear_s;
    logic             tick_s;
    logic             adv_s;
    logic [CNT_W-1:0] count_s;
    tod_t             time_inc_s;
    logic             day_wrap_s;
    logic [31:0]      rd32_s;
    logic             unused_wd_s;

    // Write data viewed as the 32-bit register layout
    assign wd32_s   = 32'(avs_writedata);
    assign wr_tod_s = {wd32_s[HOUR_LSB +: 5], wd32_s[MIN_LSB +: 6], wd32_s[SEC_LSB +: 6]};
    assign unused_wd_s = ^{wd32_s[31:21], wd32_s[15:14], wd32_s[7:6]};

    // Bus write decode; a TIME write with any out-of-range field is dropped
    assign load_time_s  = avs_write && (avs_address == A_TIME) && tod_valid(wr_tod_s);
    assign ctrl_wr_s    = avs_write && (avs_address == A_CTRL);
    assign clear_s      = ctrl_wr_s && wd32_s[1];
    assign status_w1c_s = avs_write && (avs_address == A_STATUS) && wd32_s[0];

    // Software loads and clears restart the second and swallow a pending tick
    assign sync_clear_s = load_time_s || clear_s;
    assign adv_s        = tick_s && !sync_clear_s;

    tick_gen #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .CNT_W       (CNT_W)
    ) u_tick_gen (
        .clk        (clk),
        .reset      (reset),
        .enable     (run_r),
        .sync_clear (sync_clear_s),
        .tick       (tick_s),
        .count      (count_s)
    );

    // Next time of day with seconds -> minutes -> hours carry and day wrap
    always_comb begin
        time_inc_s = time_r;
        day_wrap_s = 1'b0;
        if (time_r.seconds == SEC_MAX) begin
            time_inc_s.seconds = 6'd0;
            if (time_r.minutes == MIN_MAX) begin
                time_inc_s.minutes = 6'd0;
                if (time_r.hours == HOUR_MAX) begin
                    time_inc_s.hours = 5'd0;
                    day_wrap_s       = 1'b1;
                end else begin
                    time_inc_s.hours = time_r.hours + 5'd1;
                end
            end else begin
                time_inc_s.minutes = time_r.minutes + 6'd1;
            end
        end else begin
            time_inc_s.seconds = time_r.seconds + 6'd1;
        end
    end

    // Time-of-day registers and the seconds pulse that accompanies each advance
    always_ff @(posedge clk) begin
        if (reset) begin
            time_r     <= TOD_ZERO;
            sec_tick_r <= 1'b0;
        end else begin
            sec_tick_r <= adv_s;
            if (load_time_s) begin
                time_r <= wr_tod_s;
            end else if (clear_s) begin
                time_r <= TOD_ZERO;
            end else if (adv_s) begin
                time_r <= time_inc_s;
            end
        end
    end

    // Run enable and sticky midnight flag; a rollover beats a coincident clear
    always_ff @(posedge clk) begin
        if (reset) begin
            run_r      <= 1'b0;
            midnight_r <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                run_r <= wd32_s[0];
            end
            if (adv_s && day_wrap_s) begin
                midnight_r <= 1'b1;
            end else if (status_w1c_s) begin
                midnight_r <= 1'b0;
            end
        end
    end

    // Read mux over current register state (pre-update values on collision)
    always_comb begin
        rd32_s = 32'h0000_0000;
        case (avs_address)
            A_TIME:     rd32_s = pack_time(time_r);
            A_CTRL:     rd32_s = {31'h0, run_r};
            A_STATUS:   rd32_s = {31'h0, midnight_r};
            A_PRESCALE: rd32_s = 32'(count_s);
            default:    rd32_s = 32'h0000_0000;
        endcase
    end

    // Read data register: captured on a read strobe, held otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_r <= {DATA_WIDTH{1'b0}};
        end else if (avs_read) begin
            readdata_r <= DATA_WIDTH'(rd32_s);
        end
    end

    assign avs_readdata    = readdata_r;
    assign avs_waitrequest = 1'b0;
    assign hours           = time_r.hours;
    assign minutes         = time_r.minutes;
    assign seconds         = time_r.seconds;
    assign sec_tick        = sec_tick_r;

endmodule

// File: tb/tb_clock_timer.sv
// Self-checking bench for clock_timer with a four-cycle second. The
// reference model keeps time as seconds-of-day and a prescaler phase and
// is stepped once per clock alongside the DUT.
module tb_clock_timer;

    localparam int unsigned FREQ = 4;
    localparam int unsigned DAY  = 86400;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  avs_address = 4'h0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'h0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [4:0]  hours;
    logic [5:0]  minutes;
    logic [5:0]  seconds;
    logic        sec_tick;

    clock_timer #(
        .CLK_FREQ_HZ (FREQ),
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .hours           (hours),
        .minutes         (minutes),
        .seconds         (seconds),
        .sec_tick        (sec_tick)
    );

    always #5 clk = ~clk;

    // Reference state
    int unsigned m_sod;
    int unsigned m_cnt;
    bit          m_run;
    bit          m_mid;
    bit          m_tick;
    logic [31:0] m_rd;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] time_word(input int unsigned sod);
        logic [31:0] w;
        w = 32'h0;
        w[20:16] = 5'(sod / 3600);
        w[13:8]  = 6'((sod / 60) % 60);
        w[5:0]   = 6'(sod % 60);
        return w;
    endfunction

    task automatic compare_all();
        check_eq("hours",    32'(hours),    m_sod / 3600);
        check_eq("minutes",  32'(minutes),  (m_sod / 60) % 60);
        check_eq("seconds",  32'(seconds),  m_sod % 60);
        check_eq("sec_tick", 32'(sec_tick), 32'(m_tick));
        check_eq("readdata", avs_readdata,  m_rd);
        check_eq("waitreq",  32'(avs_waitrequest), 32'h0);
    endtask

    // One bus cycle: drive, advance the model by the rules, clock, compare
    task automatic cycle(input logic rd, input logic wr, input logic [3:0] a, input logic [31:0] wd);
        int unsigned h, mi, s;
        bit tick, busy, pulse, setmid, clrmid, new_run;
        avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = wd;
        tick = m_run && (m_cnt == FREQ - 1);
        busy = 1'b0; pulse = 1'b0; setmid = 1'b0; clrmid = 1'b0; new_run = m_run;
        if (rd) begin
            case (a)
                4'd0:    m_rd = time_word(m_sod);
                4'd1:    m_rd = {31'h0, m_run};
                4'd2:    m_rd = {31'h0, m_mid};
                4'd3:    m_rd = m_cnt;
                default: m_rd = 32'h0;
            endcase
        end
        if (wr) begin
            case (a)
                4'd0: begin
                    h = 32'(wd[20:16]); mi = 32'(wd[13:8]); s = 32'(wd[5:0]);
                    if (h < 24 && mi < 60 && s < 60) begin
                        m_sod = h * 3600 + mi * 60 + s;
                        busy = 1'b1;
                    end
                end
                4'd1: begin
                    new_run = wd[0];
                    if (wd[1]) begin
                        m_sod = 0;
                        busy = 1'b1;
                    end
                end
                4'd2:    clrmid = wd[0];
                default: ;
            endcase
        end
        if (busy) begin
            m_cnt = 0;
        end else if (m_run) begin
            m_cnt = (m_cnt + 1) % FREQ;
            if (tick) begin
                m_sod = (m_sod + 1) % DAY;
                pulse = 1'b1;
                setmid = (m_sod == 0);
            end
        end
        if (setmid) m_mid = 1'b1;
        else if (clrmid) m_mid = 1'b0;
        m_run = new_run;
        m_tick = pulse;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    // Idle until the next cycle is the tick cycle (bounded)
    task automatic wait_phase();
        for (int i = 0; i < int'(FREQ) + 1 && m_cnt != FREQ - 1; i++) idle(1);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        avs_read = 1'b0; avs_write = 1'b0; avs_address = 4'h0; avs_writedata = 32'h0;
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
        m_sod = 0; m_cnt = 0; m_run = 1'b0; m_mid = 1'b0; m_tick = 1'b0; m_rd = 32'h0;
        compare_all();
        reset = 1'b0;
    endtask

    initial begin
        int unsigned r, h, mi, s;
        logic [31:0] wd;

        do_reset(2);

        // Run from reset; PRESCALE walks 0..3 and the first second lands after 4 cycles
        cycle(1'b0, 1'b1, 4'd1, 32'h1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 4'd3, 32'h0);
            check_eq("presc_phase", avs_readdata, i);
        end
        check_eq("first_second", 32'(seconds), 32'd1);
        check_eq("first_tick", 32'(sec_tick), 32'd1);
        idle(8);

        // Midnight rollover and write-1-to-clear of the flag
        cycle(1'b0, 1'b1, 4'd0, 32'h0017_3B3B);
        wait_phase();
        idle(1);
        check_eq("midnight_time", {27'h0, hours, minutes, seconds}, 32'h0);
        cycle(1'b1, 1'b0, 4'd2, 32'h0);
        check_eq("midnight_set", avs_readdata, 32'h1);
        cycle(1'b0, 1'b1, 4'd2, 32'h1);
        cycle(1'b1, 1'b0, 4'd2, 32'h0);
        check_eq("midnight_clr", avs_readdata, 32'h0);

        // Out-of-range TIME writes are ignored; run off holds time
        cycle(1'b0, 1'b1, 4'd1, 32'h0);
        cycle(1'b0, 1'b1, 4'd0, 32'h0018_0000);
        cycle(1'b0, 1'b1, 4'd0, 32'h0000_3C00);
        cycle(1'b1, 1'b0, 4'd0, 32'h0);
        idle(6);

        // TIME write in the tick cycle wins; next second a full period later
        cycle(1'b0, 1'b1, 4'd1, 32'h1);
        wait_phase();
        cycle(1'b0, 1'b1, 4'd0, 32'h0001_0203);
        check_eq("load_tick_suppr", 32'(sec_tick), 32'd0);
        check_eq("load_time", {11'h0, hours, 2'h0, minutes, 2'h0, seconds}, 32'h0001_0203);
        idle(3);
        check_eq("load_hold", 32'(seconds), 32'd3);
        idle(1);
        check_eq("load_next", 32'(seconds), 32'd4);

        // Clear with run: time zeroed, CTRL reads run only, counting continues
        cycle(1'b0, 1'b1, 4'd0, 32'h0005_0607);
        cycle(1'b0, 1'b1, 4'd1, 32'h3);
        check_eq("clear_time", {27'h0, hours, minutes, seconds}, 32'h0);
        cycle(1'b1, 1'b0, 4'd1, 32'h0);
        check_eq("clear_ctrl", avs_readdata, 32'h1);
        idle(3);
        check_eq("clear_counts", 32'(seconds), 32'd1);

        // Reset at the tick phase drops the pending second
        wait_phase();
        do_reset(1);
        check_eq("rst_no_tick", 32'(sec_tick), 32'd0);
        idle(6);
        check_eq("rst_hold", 32'(seconds), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 50) begin
                cycle(1'b0, 1'b0, 4'($urandom), $urandom);
            end else if (r < 72) begin
                cycle(1'b1, 1'b0, 4'($urandom_range(0, 15)), 32'h0);
            end else if (r < 84) begin
                if ($urandom_range(0, 3) == 0) begin
                    h = 23; mi = 59; s = $urandom_range(55, 59);
                end else begin
                    h = $urandom_range(0, 25); mi = $urandom_range(0, 61); s = $urandom_range(0, 61);
                end
                wd = ($urandom & 32'hFFE0_C0C0) | (h << 16) | (mi << 8) | s;
                cycle(1'($urandom_range(0, 1)), 1'b1, 4'd0, wd);
            end else if (r < 92) begin
                wd = {30'h0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0)};
                cycle(1'($urandom_range(0, 1)), 1'b1, 4'd1, wd);
            end else if (r < 96) begin
                cycle(1'($urandom_range(0, 1)), 1'b1, 4'd2, $urandom);
            end else begin
                cycle(1'b0, 1'b1, 4'($urandom_range(3, 15)), $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_timer.md
CLOCK_TIMER -- requirements
Module: clock_timer

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50_000_000, clk cycles per second (minimum 2).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, Avalon-MM data width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4, Avalon-MM word address width.
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port avs_address, input, ADDR_WIDTH, register word address.
REQ-007 SHALL have ports avs_read and avs_write, input, 1 each, access strobes.
REQ-008 SHALL have port avs_writedata, input, DATA_WIDTH, write data.
REQ-009 SHALL have port avs_readdata, output, DATA_WIDTH, registered read data.
REQ-010 SHALL have port avs_waitrequest, output, 1, tied 0.
REQ-011 SHALL have port hours, output, 5, current hour 0-23, feeding the HEX display stage.
REQ-012 SHALL have port minutes, output, 6, current minute 0-59.
REQ-013 SHALL have port seconds, output, 6, current second 0-59.
REQ-014 SHALL have port sec_tick, output, 1, one-cycle pulse on each seconds increment.

Function
REQ-015 SHALL use a prescaler counting 0..CLK_FREQ_HZ-1 while run=1, with tick asserted in the cycle where the count is CLK_FREQ_HZ-1, then wrapping to 0.
REQ-016 SHALL hold the prescaler and time when run=0, with no tick.
REQ-017 SHALL, on tick, update seconds/minutes/hours one cycle later and pulse sec_tick in that same cycle.
REQ-018 SHALL cascade: seconds 59->0 increments minutes; minutes 59->0 increments hours; hours 23->0 sets the sticky status bit MIDNIGHT.
REQ-019 SHALL decode registers: 0x0 TIME RW {11'h0,hours,2'h0,minutes,2'h0,seconds}; 0x1 CTRL RW bit0 run, bit1 clear; 0x2 STATUS bit0 MIDNIGHT (write 1 to clear); 0x3 PRESCALE RO current prescaler count; other addresses read 0 and ignore writes.
REQ-020 SHALL register avs_readdata one cycle after avs_read and hold its value otherwise.
REQ-021 SHALL accept a TIME write only if hours<=23, minutes<=59 and seconds<=59; an invalid write SHALL be ignored in full.
REQ-022 SHALL, on an accepted TIME write, load all three fields and clear the prescaler to 0.
REQ-023 SHALL give a TIME write priority over a coincident tick, suppressing both the increment and sec_tick.
REQ-024 SHALL treat CTRL bit1 (clear) as self-clearing: writing 1 zeroes time and prescaler next cycle, reads back 0, and leaves run as written.
REQ-025 SHALL give a coincident hardware set of MIDNIGHT priority over its write-1-to-clear.
REQ-026 SHALL return the pre-update value when a read coincides with a time update.

Reset
REQ-027 SHALL, while reset=1 at a clk edge, set hours, minutes, seconds, prescaler, run, MIDNIGHT, sec_tick and avs_readdata to 0.
REQ-028 SHALL let reset mid-count abandon any pending tick without generating sec_tick.

Structure
REQ-029 SHALL place the register address constants, field limits (23/59) and the TIME packing offsets in the shared package clock_timer_pkg, which the HEX stage also uses.
REQ-030 SHALL implement the prescaler as sub-module tick_gen (inputs clk, reset, enable, sync_clear; output tick).

Verification (CLK_FREQ_HZ=4)
REQ-031 Reset, then CTRL=1 -> sec_tick every 4 cycles; seconds 0->1 after 4 cycles; PRESCALE reads 0..3 cycling.
REQ-032 TIME={23,59,59}, run -> next tick gives 0:00:00, MIDNIGHT=1; STATUS write 1 -> MIDNIGHT=0.
REQ-033 TIME write {24,0,0} or {0,60,0} -> TIME reads unchanged.
REQ-034 TIME write {1,2,3} in the tick cycle -> reads 1:02:03, no sec_tick, next increment 4 cycles later.
REQ-035 CTRL=3 at 5:06:07 -> 0:00:00, CTRL reads 1, counting continues.
REQ-036 reset asserted at prescaler count 3 -> no sec_tick; all outputs 0; run=0 holds time.
